request_unit: RTL and testbench
===============================

# request_unit

Sequences memory requests for the CPU core, sitting directly downstream of the control unit and upstream of the memory/cache interface. It turns the control unit's decoded `iREN`/`dREN`/`dWEN`/`halt` into a fetch-then-data-access handshake with the memory side (`ihit`/`dhit`), and generates the PC advance strobe. It also keeps saturating instruction and stall counters for performance checks.

## Interface
- `CNT_W`, default 32: width of the instruction and stall counters.

- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  1  instruction read enable from the control unit.
- `dREN`  in  1  data read request of the current instruction, from the control unit.
- `dWEN`  in  1  data write request of the current instruction, from the control unit.
- `halt`  in  1  the current instruction is a halt, from the control unit.
- `ihit`  in  1  instruction memory completion strobe.
- `dhit`  in  1  data memory completion strobe.
- `imemREN`  out  1  instruction read request to memory.
- `dmemREN`  out  1  data read request to memory (registered).
- `dmemWEN`  out  1  data write request to memory (registered).
- `PC_WEN`  out  1  PC update enable, single-cycle strobe.
- `halted`  out  1  sticky flag: the core has halted.
- `instr_count`  out  `CNT_W`  number of retired instructions, saturating.
- `stall_count`  out  `CNT_W`  number of cycles spent waiting on memory, saturating.

## Operation
- **Reset.** One clock, `CLK`. Reset is asynchronous, active-low (`nRST`). While `nRST` is low:
  - state goes to FETCH;
  - `dmemREN`, `dmemWEN`, `halted`, `instr_count` and `stall_count` are 0;
  - `imemREN` and `PC_WEN` are forced to 0.
- **FETCH state.**
  - `imemREN` = `iREN`; `dmemREN` = `dmemWEN` = 0.
  - On `ihit` with `halt` = 1: go to HALT. `PC_WEN` = 0 and `instr_count` is not incremented. `halt` takes precedence over `dREN`/`dWEN`.
  - On `ihit` with `dWEN` = 1: go to DATA and set `dmemWEN` = 1, `dmemREN` = 0. If `dREN` and `dWEN` are both 1, write wins.
  - On `ihit` with `dREN` = 1 only: go to DATA and set `dmemREN` = 1.
  - On `ihit` with no data request: `PC_WEN` = 1 this cycle, `instr_count` increments, stay in FETCH.
  - No `ihit`: `stall_count` increments.
- **DATA state.**
  - `imemREN` = 0; `dmemREN`/`dmemWEN` hold their latched values.
  - Control-unit inputs are ignored. The datapath holds the instruction stable.
  - On `dhit`: `PC_WEN` = 1, `instr_count` increments, `dmemREN`/`dmemWEN` clear at the same edge, go to FETCH.
  - No `dhit`: `stall_count` increments.
- **HALT state.**
  - `halted` = 1; `imemREN` = `dmemREN` = `dmemWEN` = `PC_WEN` = 0.
  - Counters freeze. The only exit is reset.
- **Ignored strobes.** `ihit` is ignored outside FETCH; `dhit` is ignored outside DATA.
- **Counters.** Each is `CNT_W` bits, unsigned, and saturates at all-ones with no wrap. At most one of the two increments per cycle.

## Timing
- `ihit`/`dhit` and the control-unit inputs are sampled at the rising edge of `CLK`.
- `PC_WEN` is combinational (Mealy): high in the same cycle as the qualifying `ihit`/`dhit`, never for more than 1 cycle per instruction.
- The data request appears the cycle after `ihit` and stays asserted until the cycle containing `dhit`, inclusive. It deasserts on the following edge.
- Minimum latencies:
  - a non-memory instruction retires in 1 cycle when `ihit` is immediate;
  - a load/store retires in 2 cycles (ihit cycle, then dhit cycle).
- `imemREN` drops in the first DATA cycle, so it is never high together with `dmemREN`/`dmemWEN`.
- `halted` rises on the edge after the halt's `ihit`.
- Reset asserted mid-DATA clears the requests immediately, without waiting for an edge. The next instruction after reset begins in FETCH.

## Test plan
- **Reset.** Hold `nRST` = 0 with `iREN` = 1 and `ihit` = 1 → every output is 0. Release reset with `iREN` = 1 → `imemREN` = 1 in the same cycle.
- **ALU stream.** `iREN` = 1, `ihit` = 1 for 5 consecutive cycles, no data requests → `PC_WEN` = 1 in each cycle, `instr_count` = 5, `stall_count` = 0.
- **Load.** `ihit` with `dREN` = 1, then `dhit` delayed 3 cycles → `dmemREN` = 1 for cycles 2–5, `imemREN` = 0 during those cycles, `PC_WEN` high only in cycle 5, `stall_count` = 3, `instr_count` = 1.
- **Write priority.** `ihit` with `dREN` = `dWEN` = 1, and a stray `ihit` while in DATA → `dmemWEN` = 1, `dmemREN` = 0, the stray `ihit` has no effect, `dhit` retires the instruction.
- **Halt.** `ihit` with `halt` = 1 and `dREN` = 1 → HALT entered, `PC_WEN` = 0, `halted` = 1 on the next edge and stays set, `dmemREN` never asserts, counters frozen.
- **Saturation.** With `CNT_W` = 4, stall for 20 cycles → `stall_count` holds at 15. Assert `nRST` = 0 mid-DATA → `dmemREN` drops asynchronously and `stall_count` = 0.

Source files
------------

// File: rtl/request_unit.sv
// request_unit
//   Sequences CPU memory requests: instruction fetch first, then an optional
//   data access. It drives the PC advance strobe and keeps saturating
//   counters of retired instructions and of memory stall cycles.
//
// Ports
//   CLK          in   system clock, rising edge
//   nRST         in   asynchronous active-low reset
//   iREN         in   instruction read enable from the control unit
//   dREN, dWEN   in   data read / write request of the current instruction
//   halt         in   current instruction is a halt
//   ihit, dhit   in   instruction / data memory completion strobes
//   imemREN      out  instruction read request (combinational, FETCH only)
//   dmemREN      out  registered data read request
//   dmemWEN      out  registered data write request
//   PC_WEN       out  single-cycle PC update strobe (Mealy)
//   halted       out  sticky halted flag
//   instr_count  out  saturating retired-instruction count
//   stall_count  out  saturating memory-wait cycle count
module request_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             PC_WEN,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             imem_ren_s;
  logic             retire_s;
  logic             stall_s;
  logic             take_halt_s;
  logic             take_write_s;
  logic             take_read_s;
  logic             data_done_s;
  logic             dmem_ren_r;
  logic             dmem_wen_r;
  logic             halted_r;
  logic [CNT_W-1:0] instr_count_r;
  logic [CNT_W-1:0] stall_count_r;

  // Next-state and per-cycle event decode for the fetch/data/halt sequence.
  always_comb begin
    state_next_s = state_r;
    imem_ren_s   = 1'b0;
    retire_s     = 1'b0;
    stall_s      = 1'b0;
    take_halt_s  = 1'b0;
    take_write_s = 1'b0;
    take_read_s  = 1'b0;
    data_done_s  = 1'b0;
    case (state_r)
      FETCH: begin
        imem_ren_s = iREN;
        if (ihit) begin
          // Halt outranks any data request; a write outranks a read.
          if (halt) begin
            take_halt_s  = 1'b1;
            state_next_s = HALT;
          end else if (dWEN) begin
            take_write_s = 1'b1;
            state_next_s = DATA;
          end else if (dREN) begin
            take_read_s  = 1'b1;
            state_next_s = DATA;
          end else begin
            retire_s     = 1'b1;
            state_next_s = FETCH;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      DATA: begin
        if (dhit) begin
          retire_s     = 1'b1;
          data_done_s  = 1'b1;
          state_next_s = FETCH;
        end else begin
          stall_s = 1'b1;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        // Unreachable encoding: recover into a clean fetch.
        state_next_s = FETCH;
      end
    endcase
  end

  // State register and latched data requests; reset clears requests at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= FETCH;
      dmem_ren_r <= 1'b0;
      dmem_wen_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (take_write_s) begin
        dmem_wen_r <= 1'b1;
        dmem_ren_r <= 1'b0;
      end else if (take_read_s) begin
        dmem_wen_r <= 1'b0;
        dmem_ren_r <= 1'b1;
      end else if (data_done_s) begin
        dmem_wen_r <= 1'b0;
        dmem_ren_r <= 1'b0;
      end
      if (take_halt_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Saturating performance counters; at most one of them moves per cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_count_r <= '0;
      stall_count_r <= '0;
    end else begin
      if (retire_s && (instr_count_r != CNT_MAX)) begin
        instr_count_r <= instr_count_r + CNT_ONE;
      end
      if (stall_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end
    end
  end

  // Combinational requests are gated off while reset is held.
  assign imemREN     = nRST & imem_ren_s;
  assign PC_WEN      = nRST & retire_s;
  assign dmemREN     = dmem_ren_r;
  assign dmemWEN     = dmem_wen_r;
  assign halted      = halted_r;
  assign instr_count = instr_count_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_request_unit.sv
module tb_request_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          nRST;
  logic          iREN, dREN, dWEN, halt, ihit, dhit;
  logic          imemREN, dmemREN, dmemWEN, PC_WEN, halted;
  logic [CW-1:0] instr_count, stall_count;

  request_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .halt(halt), .ihit(ihit), .dhit(dhit), .imemREN(imemREN),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .PC_WEN(PC_WEN), .halted(halted),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected output vector: {imemREN, dmemREN, dmemWEN, PC_WEN, halted, instr, stall}
  logic [12:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit done     = 0;

  // Reference model: what the core is doing, as plain variables.
  // mode 0 = fetching, 1 = waiting for data memory, 2 = halted for good.
  int m_mode   = 0;
  bit m_load   = 0;
  bit m_store  = 0;
  bit m_halted = 0;
  int m_instr  = 0;
  int m_stall  = 0;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One clock of stimulus; expected outputs for this cycle go into the queue,
  // then the model moves to where it will be after the coming rising edge.
  task automatic step(input bit rst, input bit ir, input bit dr, input bit dw,
                      input bit hl, input bit ih, input bit dh);
    bit e_imem, e_pc;
    @(posedge CLK);
    #1;
    nRST = rst; iREN = ir; dREN = dr; dWEN = dw; halt = hl; ihit = ih; dhit = dh;
    e_imem = 0;
    e_pc   = 0;
    if (!rst) begin
      m_mode = 0; m_load = 0; m_store = 0; m_halted = 0; m_instr = 0; m_stall = 0;
      exp_q.push_back(13'd0);
    end else begin
      if (m_mode == 0) e_imem = ir;
      if (m_mode == 0 && ih && !hl && !dr && !dw) e_pc = 1;
      if (m_mode == 1 && dh) e_pc = 1;
      exp_q.push_back({e_imem, m_load, m_store, e_pc, m_halted,
                       m_instr[CW-1:0], m_stall[CW-1:0]});
      if (m_mode == 0) begin
        if (!ih) m_stall = sat_inc(m_stall);
        else if (hl) begin m_mode = 2; m_halted = 1; end
        else if (dw) begin m_mode = 1; m_store = 1; m_load = 0; end
        else if (dr) begin m_mode = 1; m_load = 1; m_store = 0; end
        else m_instr = sat_inc(m_instr);
      end else if (m_mode == 1) begin
        if (dh) begin
          m_mode = 0; m_load = 0; m_store = 0;
          m_instr = sat_inc(m_instr);
        end else begin
          m_stall = sat_inc(m_stall);
        end
      end
    end
    cyc++;
  endtask

  // Monitor: every falling edge the DUT presents one cycle's outputs.
  always @(negedge CLK) begin
    logic [12:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {imemREN, dmemREN, dmemWEN, PC_WEN, halted, instr_count, stall_count};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL outputs cycle %0d: got imem=%b dren=%b dwen=%b pc=%b halted=%b instr=%0d stall=%0d, expected imem=%b dren=%b dwen=%b pc=%b halted=%b instr=%0d stall=%0d",
                 cyc, act_v[12], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:4], act_v[3:0],
                 exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ihit = 0; dhit = 0;

    // Reset held with fetch activity present: everything must read 0.
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    // Release: instruction request visible in the same cycle.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Five back-to-back single-cycle instructions.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Load with data completion three cycles late.
    step(1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Read and write together: write wins; a stray ihit during DATA is ignored.
    step(1, 1, 1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Halt beats a data read; afterwards nothing moves.
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Stall counter saturates at all-ones.
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
    // Reset asserted mid-DATA drops the request before any edge.
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);

    // Instruction counter saturation.
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 1) == 1));
    end

    // Drain: the monitor must have consumed every expectation.
    repeat (3) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
